// File: rtl/fifo_tx_scheduler.sv
// fifo_tx_scheduler: controller around the 80-to-8 width-converting FIFO.
// Write side: round-robin arbiter between two held-valid 80-bit producers.
// Read side: drains the FIFO as frames of SYNC byte, one word (byte 0 first)
// and an XOR checksum of the payload bytes.
module fifo_tx_scheduler #(
   parameter int         WORD_BITS  = 80,
   parameter int         WORD_BYTES = 10,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0_valid,
   input  logic [WORD_BITS-1:0] req0_data,
   output logic                 ack0,
   input  logic                 req1_valid,
   input  logic [WORD_BITS-1:0] req1_data,
   output logic                 ack1,
   output logic                 fifo_wr_en,
   output logic [WORD_BITS-1:0] fifo_din,
   input  logic                 fifo_full,
   output logic                 fifo_rd_en,
   input  logic [7:0]           fifo_dout,
   input  logic                 fifo_empty,
   input  logic [7:0]           fifo_bytes_avail,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [CNT_W-1:0]     frame_cnt
);

   localparam int IDX_W = $clog2(WORD_BYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SYNC    = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CSUM    = 2'd3
   } state_t;

   // Running frame checksum: XOR of all payload bytes.
   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

   // ------------------------------------------------------------------
   // Write arbiter
   // ------------------------------------------------------------------
   logic                 ack0_q, ack1_q, wr_en_q, last_grant_q;
   logic [WORD_BITS-1:0] din_q;
   logic                 grant_ok_s, grant0_s, grant1_s;

   // Pick a winner; a cycle after any grant is blocked so a held request is never taken twice.
   always_comb begin
      grant0_s   = 1'b0;
      grant1_s   = 1'b0;
      grant_ok_s = !fifo_full && !wr_en_q && !ack0_q && !ack1_q;
      if (grant_ok_s) begin
         if (req0_valid && req1_valid) begin
            if (last_grant_q) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end else if (req0_valid) begin
            grant0_s = 1'b1;
         end else if (req1_valid) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b0;
         end
      end else begin
         grant1_s = 1'b0;
      end
   end

   // Register the grant as one-cycle ack/write pulses and remember the winner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         din_q        <= '0;
         last_grant_q <= 1'b1;
      end else begin
         ack0_q  <= grant0_s;
         ack1_q  <= grant1_s;
         wr_en_q <= grant0_s | grant1_s;
         if (grant0_s) begin
            din_q        <= req0_data;
            last_grant_q <= 1'b0;
         end else if (grant1_s) begin
            din_q        <= req1_data;
            last_grant_q <= 1'b1;
         end
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign fifo_wr_en = wr_en_q;
   assign fifo_din   = din_q;

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [7:0]         csum_q, csum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic               start_s, last_byte_s;

   assign start_s     = !fifo_empty && (fifo_bytes_avail >= 8'(WORD_BYTES));
   assign last_byte_s = (idx_q == IDX_W'(WORD_BYTES - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; every non-idle state offers a byte, so tx_ready is the handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_SYNC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SYNC: begin
            if (tx_ready) begin
               state_d = S_PAYLOAD;
            end else begin
               state_d = S_SYNC;
            end
         end
         S_PAYLOAD: begin
            if (tx_ready && last_byte_s) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_PAYLOAD;
            end
         end
         S_CSUM: begin
            if (tx_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_CSUM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: checksum/index cleared at frame start, updated on payload handshakes.
   always_comb begin
      csum_d      = csum_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               csum_d = 8'h00;
               idx_d  = '0;
            end else begin
               idx_d  = idx_q;
            end
         end
         S_PAYLOAD: begin
            if (tx_ready) begin
               csum_d = csum_update(csum_q, fifo_dout);
               idx_d  = idx_q + IDX_W'(1'b1);
            end else begin
               idx_d  = idx_q;
            end
         end
         S_CSUM: begin
            if (tx_ready) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
            end else begin
               frame_cnt_d = frame_cnt_q;
            end
         end
         default: csum_d = csum_q;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum_q      <= 8'h00;
         idx_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         csum_q      <= csum_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Output decode; payload bytes pass straight from the FIFO head and pop on the handshake.
   always_comb begin
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      busy       = 1'b0;
      fifo_rd_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_SYNC: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
            busy     = 1'b1;
         end
         S_PAYLOAD: begin
            tx_valid   = 1'b1;
            tx_data    = fifo_dout;
            busy       = 1'b1;
            fifo_rd_en = tx_ready;
         end
         S_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
            busy     = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Self-checking bench for fifo_tx_scheduler: a queue-based FIFO model feeds the
// read side, a frame-level reference builds the expected byte stream from the
// arbitration rules, and each test task compares the DUT against it.
module tb_fifo_tx_scheduler;
   localparam int WB  = 80;
   localparam int NB  = 10;
   localparam int CW  = 4;   // narrow frame counter so wrap-around is reachable quickly
   localparam int CAP = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [WB-1:0] req0_data = '0, req1_data = '0;
   logic          ack0, ack1, fifo_wr_en, fifo_rd_en, tx_valid, busy;
   logic [WB-1:0] fifo_din;
   logic          fifo_full;
   logic [7:0]    fifo_dout = 8'h00, fifo_bytes_avail = 8'h00, tx_data;
   logic          fifo_empty = 1'b1;
   logic          tx_ready = 1'b0;
   logic [CW-1:0] frame_cnt;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   fifo_tx_scheduler #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .ack0(ack0),
      .req1_valid(req1_valid), .req1_data(req1_data), .ack1(ack1),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_bytes_avail(fifo_bytes_avail),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .frame_cnt(frame_cnt));

   // ---------------- FIFO model (byte queue) ----------------
   logic [7:0] fq[$];
   logic       fifo_clear = 1'b0, model_full = 1'b0, force_full = 1'b0;
   assign fifo_full = model_full | force_full;

   always @(posedge clk) begin
      if (fifo_clear) fq.delete();
      else begin
         if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
         if (fifo_wr_en) for (int i = 0; i < NB; i++) fq.push_back(fifo_din[8*i +: 8]);
      end
      fifo_dout        <= (fq.size() > 0) ? fq[0] : 8'h00;
      fifo_bytes_avail <= 8'(fq.size());
      fifo_empty       <= (fq.size() == 0);
      model_full       <= (fq.size() > CAP - NB);
   end

   // ---------------- Reference model ----------------
   logic          m_ack0 = 1'b0, m_ack1 = 1'b0, m_last = 1'b1;
   logic [WB-1:0] m_din = '0;
   int            words_since_rst = 0;
   logic [7:0]    exp_q[$], obs_q[$];

   task automatic push_frame(input logic [WB-1:0] w);
      logic [7:0] x;
      x = 8'h00;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(w[8*i +: 8]);
         x = x ^ w[8*i +: 8];
      end
      exp_q.push_back(x);
      words_since_rst++;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_last <= 1'b1;
      end else begin
         m_ack0 <= 1'b0; m_ack1 <= 1'b0;
         if (!fifo_full && !m_ack0 && !m_ack1 && (req0_valid || req1_valid)) begin
            if (req0_valid && !(req1_valid && !m_last)) begin
               m_ack0 <= 1'b1; m_last <= 1'b0; m_din <= req0_data; push_frame(req0_data);
            end else begin
               m_ack1 <= 1'b1; m_last <= 1'b1; m_din <= req1_data; push_frame(req1_data);
            end
         end
      end
   end

   // ---------------- Producers ----------------
   logic [WB-1:0] p0q[$], p1q[$];
   always @(negedge clk) begin
      if (ack0 && p0q.size() > 0) void'(p0q.pop_front());
      if (ack1 && p1q.size() > 0) void'(p1q.pop_front());
      req0_valid = (p0q.size() > 0);
      req0_data  = req0_valid ? p0q[0] : '0;
      req1_valid = (p1q.size() > 0);
      req1_data  = req1_valid ? p1q[0] : '0;
   end

   // tx_ready pattern: 0 = held by tasks, 1 = toggle, 2 = random
   int ready_mode = 0;
   always @(negedge clk) begin
      if (ready_mode == 1) tx_ready = ~tx_ready;
      else if (ready_mode == 2) tx_ready = $urandom_range(0, 1) == 1;
   end

   // ---------------- Monitors ----------------
   int   arb_mis = 0, stab_mis = 0, rd_mis = 0, rd_cnt = 0;
   int   ack_log[$];
   logic stall_pend = 1'b0;
   logic [7:0] stall_data = 8'h00;

   always @(negedge clk) begin
      if (reset) begin
         if (ack0 !== m_ack0 || ack1 !== m_ack1 || fifo_wr_en !== (m_ack0 | m_ack1)) arb_mis++;
         if (fifo_wr_en && fifo_din !== m_din) arb_mis++;
         if (ack0) ack_log.push_back(0);
         if (ack1) ack_log.push_back(1);
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         if (stall_pend && (!tx_valid || tx_data !== stall_data)) stab_mis++;
         if (tx_valid && tx_ready) obs_q.push_back(tx_data);
         stall_pend = tx_valid && !tx_ready;
         stall_data = tx_data;
         if (fifo_rd_en) begin
            rd_cnt++;
            if (!(tx_valid && tx_ready) || fifo_empty) rd_mis++;
         end
      end
   end

   // ---------------- Utilities ----------------
   function automatic int stream_bad();
      int bad = 0;
      if (obs_q.size() != exp_q.size()) bad++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) bad++;
      return bad;
   endfunction

   function automatic logic [WB-1:0] rand_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[WB-1:0];
   endfunction

   task automatic clear_logs();
      obs_q.delete(); exp_q.delete(); ack_log.delete();
      arb_mis = 0; stab_mis = 0; rd_mis = 0; rd_cnt = 0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (p0q.size() == 0 && p1q.size() == 0 && fq.size() == 0 && !busy &&
             !ack0 && !ack1 && !fifo_wr_en && !m_ack0 && !m_ack1) quiet++;
         else quiet = 0;
         if (quiet >= 3) begin ok = 1'b1; break; end
      end
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      reset = 1'b0; tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({ack0, ack1, fifo_wr_en, fifo_rd_en, tx_valid, busy} !== 6'b0) begin
         $display("FAIL reset_ctrl: got %b, need 000000", {ack0, ack1, fifo_wr_en, fifo_rd_en, tx_valid, busy});
      end else passed++;
      total++;
      if (fifo_din !== '0 || tx_data !== 8'h00) begin
         $display("FAIL reset_data: din=%h tx_data=%h, need 0", fifo_din, tx_data);
      end else passed++;
      total++;
      if (frame_cnt !== '0) $display("FAIL reset_frame_cnt: got %0d, need 0", frame_cnt);
      else passed++;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL idle_after_reset: busy=%b tx_valid=%b, need 0/0", busy, tx_valid);
      else passed++;
   endtask

   task automatic test_single_word();
      logic [7:0] ref1 [12];
      bit ok;
      int bad;
      ref1 = '{8'hA5, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h01};
      clear_logs();
      tx_ready = 1'b1;
      p0q.push_back(80'h00_0102030405060708_09);
      wait_drain(400, ok);
      total++;
      if (!ok) $display("FAIL single_drain: timed out, need drained"); else passed++;
      bad = (obs_q.size() != 12) ? 1 : 0;
      for (int i = 0; i < 12 && i < obs_q.size(); i++) if (obs_q[i] !== ref1[i]) bad++;
      total++;
      if (bad !== 0) $display("FAIL single_bytes: %0d wrong of %0d observed, need 12 exact", bad, obs_q.size());
      else passed++;
      total++;
      if (ack_log.size() !== 1 || ack_log[0] !== 0) $display("FAIL single_ack: %0d acks, need one ack0", ack_log.size());
      else passed++;
      total++;
      if (frame_cnt !== 4'd1) $display("FAIL single_frame_cnt: got %0d, need 1", frame_cnt); else passed++;
      total++;
      if (rd_cnt !== NB) $display("FAIL single_rd_cnt: got %0d, need %0d", rd_cnt, NB); else passed++;
   endtask

   task automatic test_alternate();
      bit ok;
      int same = 0;
      clear_logs();
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p0q.push_back(rand_word());
         p1q.push_back(rand_word());
      end
      wait_drain(2000, ok);
      for (int i = 1; i < ack_log.size(); i++) if (ack_log[i] == ack_log[i-1]) same++;
      total++;
      if (!ok || ack_log.size() !== 8 || same !== 0)
         $display("FAIL alternate_acks: drained=%0d acks=%0d repeats=%0d, need 1/8/0", ok, ack_log.size(), same);
      else passed++;
      total++;
      if (ack_log.size() > 0 && ack_log[0] !== 1) $display("FAIL alternate_first: got ack%0d, need ack1", ack_log[0]);
      else passed++;
      total++;
      if (arb_mis !== 0) $display("FAIL alternate_arb: %0d mismatches, need 0", arb_mis); else passed++;
      total++;
      if (stream_bad() !== 0) $display("FAIL alternate_stream: %0d bad (obs %0d exp %0d), need 0", stream_bad(), obs_q.size(), exp_q.size());
      else passed++;
      total++;
      if (frame_cnt !== CW'(words_since_rst)) $display("FAIL alternate_frame_cnt: got %0d, need %0d", frame_cnt, CW'(words_since_rst));
      else passed++;
   endtask

   task automatic test_full_block();
      bit ok;
      int seen = 0;
      logic [WB-1:0] w;
      clear_logs();
      tx_ready = 1'b1;
      force_full = 1'b1;
      w = rand_word();
      p1q.push_back(w);
      repeat (10) begin
         @(negedge clk);
         if (ack0 || ack1 || fifo_wr_en) seen++;
      end
      total++;
      if (seen !== 0) $display("FAIL full_blocks: %0d grant cycles while full, need 0", seen); else passed++;
      force_full = 1'b0;
      @(negedge clk);
      total++;
      if (ack1 !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_din !== w)
         $display("FAIL full_release: ack1=%b wr=%b din=%h, need 1/1/%h", ack1, fifo_wr_en, fifo_din, w);
      else passed++;
      wait_drain(400, ok);
      total++;
      if (!ok || stream_bad() !== 0) $display("FAIL full_stream: drained=%0d bad=%0d, need 1/0", ok, stream_bad());
      else passed++;
   endtask

   task automatic test_stall(input int mode, input int nwords);
      bit ok;
      clear_logs();
      ready_mode = mode;
      for (int i = 0; i < nwords; i++) begin
         if ($urandom_range(0, 1) == 1) p1q.push_back(rand_word());
         else p0q.push_back(rand_word());
      end
      wait_drain(4000, ok);
      ready_mode = 0;
      tx_ready = 1'b1;
      total++;
      if (!ok || stream_bad() !== 0)
         $display("FAIL stall%0d_stream: drained=%0d bad=%0d (obs %0d exp %0d), need 1/0", mode, ok, stream_bad(), obs_q.size(), exp_q.size());
      else passed++;
      total++;
      if (rd_cnt !== NB * nwords) $display("FAIL stall%0d_rd_cnt: got %0d, need %0d", mode, rd_cnt, NB * nwords);
      else passed++;
      total++;
      if (stab_mis !== 0 || rd_mis !== 0) $display("FAIL stall%0d_hold: unstable=%0d bad_pops=%0d, need 0/0", mode, stab_mis, rd_mis);
      else passed++;
      total++;
      if (arb_mis !== 0) $display("FAIL stall%0d_arb: %0d mismatches, need 0", mode, arb_mis); else passed++;
      total++;
      if (frame_cnt !== CW'(words_since_rst)) $display("FAIL stall%0d_frame_cnt: got %0d, need %0d", mode, frame_cnt, CW'(words_since_rst));
      else passed++;
   endtask

   task automatic test_reset_mid();
      bit reached = 1'b0;
      clear_logs();
      tx_ready = 1'b1;
      p0q.push_back(rand_word());
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (rd_cnt == 4) begin reached = 1'b1; break; end
      end
      total++;
      if (!reached || busy !== 1'b1) $display("FAIL midreset_reach: reached=%0d busy=%b, need 1/1", reached, busy);
      else passed++;
      #2 reset = 1'b0;
      #1;
      total++;
      if ({ack0, ack1, fifo_wr_en, fifo_rd_en, tx_valid, busy} !== 6'b0 || tx_data !== 8'h00 || frame_cnt !== '0)
         $display("FAIL midreset_async: ctrl=%b tx_data=%h frame_cnt=%0d, need 0", {ack0, ack1, fifo_wr_en, fifo_rd_en, tx_valid, busy}, tx_data, frame_cnt);
      else passed++;
      fifo_clear = 1'b1;
      repeat (2) @(negedge clk);
      fifo_clear = 1'b0;
      p0q.delete(); p1q.delete();
      clear_logs();
      words_since_rst = 0;
      stall_pend = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || frame_cnt !== '0)
         $display("FAIL midreset_after: busy=%b tx_valid=%b frame_cnt=%0d, need 0/0/0", busy, tx_valid, frame_cnt);
      else passed++;
   endtask

   task automatic test_wrap();
      bit ok;
      clear_logs();
      tx_ready = 1'b1;
      p0q.push_back(rand_word());
      p1q.push_back(rand_word());
      for (int i = 0; i < 13; i++) p0q.push_back(rand_word());
      wait_drain(4000, ok);
      total++;
      if (!ok || ack_log.size() == 0 || ack_log[0] !== 0) $display("FAIL wrap_first_tie: drained=%0d, need ack0 first", ok);
      else passed++;
      total++;
      if (frame_cnt !== 4'd15) $display("FAIL wrap_pre: got %0d, need 15", frame_cnt); else passed++;
      p1q.push_back(rand_word());
      wait_drain(400, ok);
      total++;
      if (!ok || frame_cnt !== 4'd0) $display("FAIL wrap_zero: drained=%0d frame_cnt=%0d, need 1/0", ok, frame_cnt);
      else passed++;
      total++;
      if (stream_bad() !== 0 || arb_mis !== 0) $display("FAIL wrap_stream: bad=%0d arb=%0d, need 0/0", stream_bad(), arb_mis);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_alternate();
      test_full_block();
      test_stall(1, 5);
      test_stall(2, 12);
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
